// File: rtl/game_pkg.sv
// Shared game constants: shell direction codes, screen limits and the
// enemy-shell controller state encoding.
package game_pkg;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_RIGHT = 3'd3;
  localparam logic [2:0] DIR_LEFT  = 3'd4;

  localparam int SCR_X_MAX = 799;
  localparam int SCR_Y_MAX = 599;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLIGHT = 2'd1,
    ST_RELOAD = 2'd2
  } shell_state_e;

  // A turret direction is usable only if it names one of the four axes.
  function automatic logic dir_valid(input logic [2:0] d);
    return (d >= DIR_UP) && (d <= DIR_LEFT);
  endfunction

endpackage

// File: rtl/bullet_step.sv
// Combinational one-frame shell advance: moves the position SPEED pixels
// along the given direction in 11-bit arithmetic and flags leaving the screen.
module bullet_step
  import game_pkg::*;
#(
  parameter int SPEED = 4,
  parameter int X_MAX = SCR_X_MAX,
  parameter int Y_MAX = SCR_Y_MAX
) (
  input  logic [9:0]  x_i,
  input  logic [9:0]  y_i,
  input  logic [2:0]  dir_i,
  output logic [10:0] next_x_o,
  output logic [10:0] next_y_o,
  output logic        oob_o
);

  localparam logic [10:0] STEP = 11'(SPEED);
  localparam logic [10:0] XLIM = 11'(X_MAX);
  localparam logic [10:0] YLIM = 11'(Y_MAX);

  logic borrow;

  // Step along the latched axis; a subtract that would go below zero
  // counts as leaving the screen even though the 11-bit result wraps.
  always_comb begin
    next_x_o = {1'b0, x_i};
    next_y_o = {1'b0, y_i};
    borrow   = 1'b0;
    case (dir_i)
      DIR_UP: begin
        next_y_o = {1'b0, y_i} - STEP;
        borrow   = ({1'b0, y_i} < STEP);
      end
      DIR_DOWN:  next_y_o = {1'b0, y_i} + STEP;
      DIR_RIGHT: next_x_o = {1'b0, x_i} + STEP;
      DIR_LEFT: begin
        next_x_o = {1'b0, x_i} - STEP;
        borrow   = ({1'b0, x_i} < STEP);
      end
      default: ;
    endcase
    oob_o = borrow || (next_x_o > XLIM) || (next_y_o > YLIM);
  end

endmodule

// File: rtl/enemy_bullet_ctrl.sv
// Enemy tank shell controller: launches the single shell on a fire request,
// advances it once per frame, ends flight on a hit, obstacle or screen
// edge, then holds off new shots for a reload interval.
module enemy_bullet_ctrl
  import game_pkg::*;
#(
  parameter int SPEED         = 4,
  parameter int X_MAX         = SCR_X_MAX,
  parameter int Y_MAX         = SCR_Y_MAX,
  parameter int HIT_HALF      = 16,
  parameter int RELOAD_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        fire,
  input  logic [9:0]  xpos_enemy,
  input  logic [9:0]  ypos_enemy,
  input  logic [2:0]  dir_enemy,
  input  logic [11:0] xpos_us,
  input  logic [11:0] ypos_us,
  input  logic        obstacle_hit,
  output logic [9:0]  xpos_bullet_red,
  output logic [9:0]  ypos_bullet_red,
  output logic [2:0]  direction_from_enemy,
  output logic        tank_enemy_hit_us,
  output logic        reloading
);

  // A reload length of zero behaves like one frame.
  localparam int RELOAD_LOAD = (RELOAD_FRAMES > 0) ? RELOAD_FRAMES - 1 : 0;
  localparam int CW          = (RELOAD_LOAD > 0) ? $clog2(RELOAD_LOAD + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RELOAD_LOAD);
  localparam logic [11:0]   HIT_LIM  = 12'(HIT_HALF);

  shell_state_e  state_q, state_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [2:0]    dir_q, dir_d;
  logic          hit_q, hit_d;
  logic          rel_q, rel_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [10:0] next_x, next_y;
  logic        out_of_bounds;
  logic [11:0] next_x12, next_y12, dist_x, dist_y;
  logic        near_us;
  logic        term;

  bullet_step #(
    .SPEED (SPEED),
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_step (
    .x_i      (x_q),
    .y_i      (y_q),
    .dir_i    (dir_q),
    .next_x_o (next_x),
    .next_y_o (next_y),
    .oob_o    (out_of_bounds)
  );

  // Square hit box around our tank, tested against the stepped position.
  always_comb begin
    next_x12 = {1'b0, next_x};
    next_y12 = {1'b0, next_y};
    dist_x   = (next_x12 >= xpos_us) ? next_x12 - xpos_us : xpos_us - next_x12;
    dist_y   = (next_y12 >= ypos_us) ? next_y12 - ypos_us : ypos_us - next_y12;
    near_us  = (dist_x <= HIT_LIM) && (dist_y <= HIT_LIM);
  end

  // State register and every output register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= DIR_NONE;
      hit_q   <= 1'b0;
      rel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      hit_q   <= hit_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Launch, per-frame advance with hit > obstacle > edge priority, reload.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    hit_d   = 1'b0;
    rel_d   = rel_q;
    cnt_d   = cnt_q;
    term    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire && dir_valid(dir_enemy)) begin
          x_d     = xpos_enemy;
          y_d     = ypos_enemy;
          dir_d   = dir_enemy;
          state_d = ST_FLIGHT;
        end
      end
      ST_FLIGHT: begin
        if (frame_tick) begin
          if (near_us) begin
            hit_d = 1'b1;
            term  = 1'b1;
          end else if (obstacle_hit || out_of_bounds) begin
            term = 1'b1;
          end else begin
            x_d = next_x[9:0];
            y_d = next_y[9:0];
          end
        end else if (obstacle_hit) begin
          term = 1'b1;
        end
        if (term) begin
          dir_d   = DIR_NONE;
          rel_d   = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ST_RELOAD;
        end
      end
      ST_RELOAD: begin
        if (frame_tick) begin
          if (cnt_q == '0) begin
            rel_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign xpos_bullet_red      = x_q;
  assign ypos_bullet_red      = y_q;
  assign direction_from_enemy = dir_q;
  assign tank_enemy_hit_us    = hit_q;
  assign reloading            = rel_q;

endmodule

// File: tb/tb_enemy_bullet_ctrl.sv
// Testbench for enemy_bullet_ctrl: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural shell model.
module tb_enemy_bullet_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frameTick;
  logic        fire;
  logic [9:0]  xposEnemy, yposEnemy;
  logic [2:0]  dirEnemy;
  logic [11:0] xposUs, yposUs;
  logic        obstacleHit;
  logic [9:0]  xposBullet, yposBullet;
  logic [2:0]  dirOut;
  logic        hitOut;
  logic        reloadOut;

  int checks = 0;
  int errors = 0;

  // Model: shell mode (0 no shell, 1 flying, 2 reloading), position,
  // direction, frames left before a new shot is allowed, hit pulse.
  int mMode, mX, mY, mDir, mLeft;
  bit mHit;

  always #5 clk = ~clk;

  enemy_bullet_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .frame_tick           (frameTick),
    .fire                 (fire),
    .xpos_enemy           (xposEnemy),
    .ypos_enemy           (yposEnemy),
    .dir_enemy            (dirEnemy),
    .xpos_us              (xposUs),
    .ypos_us              (yposUs),
    .obstacle_hit         (obstacleHit),
    .xpos_bullet_red      (xposBullet),
    .ypos_bullet_red      (yposBullet),
    .direction_from_enemy (dirOut),
    .tank_enemy_hit_us    (hitOut),
    .reloading            (reloadOut)
  );

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelStep();
    int nx, ny;
    bit borrow, outside, near, term;
    mHit = 1'b0;
    term = 1'b0;
    if (rst) begin
      mMode = 0; mX = 0; mY = 0; mDir = 0; mLeft = 0;
    end else if (mMode == 0) begin
      if (fire && dirEnemy >= 1 && dirEnemy <= 4) begin
        mMode = 1; mX = xposEnemy; mY = yposEnemy; mDir = dirEnemy;
      end
    end else if (mMode == 1) begin
      if (frameTick) begin
        nx = mX; ny = mY;
        if (mDir == 1) ny = ny - 4;
        if (mDir == 2) ny = ny + 4;
        if (mDir == 3) nx = nx + 4;
        if (mDir == 4) nx = nx - 4;
        borrow = (nx < 0) || (ny < 0);
        if (nx < 0) nx = nx + 2048;
        if (ny < 0) ny = ny + 2048;
        outside = borrow || nx > 799 || ny > 599;
        near = iabs(nx - int'(xposUs)) <= 16 && iabs(ny - int'(yposUs)) <= 16;
        if (near) begin
          mHit = 1'b1; term = 1'b1;
        end else if (obstacleHit || outside) begin
          term = 1'b1;
        end else begin
          mX = nx; mY = ny;
        end
      end else if (obstacleHit) begin
        term = 1'b1;
      end
      if (term) begin
        mMode = 2; mDir = 0; mLeft = 30;
      end
    end else begin
      if (frameTick) begin
        mLeft = mLeft - 1;
        if (mLeft == 0) mMode = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".x"}, 12'(xposBullet), 12'(mX));
    check({tag, ".y"}, 12'(yposBullet), 12'(mY));
    check({tag, ".dir"}, 12'(dirOut), 12'(mDir));
    check({tag, ".hit"}, 12'(hitOut), 12'(mHit));
    check({tag, ".reload"}, 12'(reloadOut), 12'(mMode == 2));
  endtask

  // Run cycles with the present inputs, checking every output after each edge.
  task automatic applyStimulus(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      modelStep();
      @(posedge clk);
      #1;
      checkOutput(tag);
    end
  endtask

  task automatic frames(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      frameTick = 1'b1;
      applyStimulus(1, tag);
      frameTick = 1'b0;
      applyStimulus(2, tag);
    end
  endtask

  task automatic shoot(input int x, input int y, input int d, input string tag);
    xposEnemy = 10'(x); yposEnemy = 10'(y); dirEnemy = 3'(d);
    fire = 1'b1;
    applyStimulus(1, tag);
    fire = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frameTick = 1'b0; fire = 1'b0; obstacleHit = 1'b0;
    xposEnemy = '0; yposEnemy = '0; dirEnemy = '0;
    xposUs = 12'd2000; yposUs = 12'd2000;
    mMode = 0; mX = 0; mY = 0; mDir = 0; mLeft = 0; mHit = 1'b0;
    applyStimulus(2, "reset");
    rst = 1'b0;
    check("reset.dir_const", 12'(dirOut), 12'd0);
    check("reset.reload_const", 12'(reloadOut), 12'd0);

    $display("[TB] upward flight and three frame steps");
    shoot(400, 300, 1, "upFire");
    check("upFire.dir_const", 12'(dirOut), 12'd1);
    frames(3, "upMove");
    check("upMove.y_const", 12'(yposBullet), 12'd288);
    check("upMove.x_const", 12'(xposBullet), 12'd400);
    obstacleHit = 1'b1;
    applyStimulus(1, "upObstacle");
    obstacleHit = 1'b0;
    check("upObstacle.dir_const", 12'(dirOut), 12'd0);
    shoot(100, 100, 2, "reloadFireIgnored");
    frames(30, "upReload");
    check("upReload.done_const", 12'(reloadOut), 12'd0);

    $display("[TB] top-edge exit and reload length");
    shoot(400, 10, 1, "edgeFire");
    frames(3, "edgeExit");
    check("edgeExit.dir_const", 12'(dirOut), 12'd0);
    check("edgeExit.reload_const", 12'(reloadOut), 12'd1);
    frames(29, "edgeReload");
    check("edgeReload.still_const", 12'(reloadOut), 12'd1);
    frames(1, "edgeReloadEnd");
    check("edgeReloadEnd.const", 12'(reloadOut), 12'd0);

    $display("[TB] shell hits our tank");
    xposUs = 12'd460; yposUs = 12'd300;
    shoot(400, 300, 3, "hitFire");
    frames(10, "hitApproach");
    check("hitApproach.x_const", 12'(xposBullet), 12'd440);
    frameTick = 1'b1;
    applyStimulus(1, "hitFrame");
    frameTick = 1'b0;
    check("hitFrame.pulse_const", 12'(hitOut), 12'd1);
    check("hitFrame.dir_const", 12'(dirOut), 12'd0);
    applyStimulus(1, "hitAfter");
    check("hitAfter.pulse_const", 12'(hitOut), 12'd0);
    frames(30, "hitReload");
    xposUs = 12'd2000; yposUs = 12'd2000;

    $display("[TB] invalid directions ignored");
    shoot(200, 200, 0, "dirZero");
    shoot(200, 200, 6, "dirSix");
    check("dirSix.dir_const", 12'(dirOut), 12'd0);

    $display("[TB] reset during flight");
    shoot(300, 300, 4, "rstFire");
    frames(2, "rstMove");
    rst = 1'b1;
    applyStimulus(1, "rstHit");
    rst = 1'b0;
    check("rstHit.x_const", 12'(xposBullet), 12'd0);
    check("rstHit.reload_const", 12'(reloadOut), 12'd0);
    shoot(50, 60, 2, "rstRefire");
    check("rstRefire.dir_const", 12'(dirOut), 12'd2);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      if (i % 60 == 0) begin
        xposUs = 12'($urandom_range(0, 900));
        yposUs = 12'($urandom_range(0, 700));
      end
      frameTick   = ($urandom_range(0, 5) == 0);
      fire        = ($urandom_range(0, 3) == 0);
      dirEnemy    = 3'($urandom_range(0, 7));
      xposEnemy   = 10'($urandom_range(0, 1023));
      yposEnemy   = 10'($urandom_range(0, 1023));
      obstacleHit = ($urandom_range(0, 60) == 0);
      rst         = ($urandom_range(0, 700) == 0);
      applyStimulus(1, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enemy_bullet_ctrl.md
# enemy_bullet_ctrl

Owns the enemy tank's single shell: launches it on a fire request, advances it once per video frame, and ends its flight on a hit on our tank, an obstacle, or the screen edge. Sits directly upstream of the opponent-bullet draw stage, which it feeds with shell position, flight direction (0 = no shell) and the hit-on-us flag. A reload interval gates the next shot.

## Interface
Parameters:
- SPEED, 4: shell step in pixels per frame.
- X_MAX, 799: last valid x pixel.
- Y_MAX, 599: last valid y pixel.
- HIT_HALF, 16: half-size of our tank's square hit box, pixels.
- RELOAD_FRAMES, 30: frames between end of flight and next accepted fire.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per frame, at vsync start.
- fire  in  1  enemy fire request, sampled every cycle.
- xpos_enemy  in  10  enemy muzzle x.
- ypos_enemy  in  10  enemy muzzle y.
- dir_enemy  in  3  enemy turret direction, 1..4.
- xpos_us  in  12  our tank centre x.
- ypos_us  in  12  our tank centre y.
- obstacle_hit  in  1  level, shell overlaps an obstacle.
- xpos_bullet_red  out  10  shell reference x.
- ypos_bullet_red  out  10  shell reference y.
- direction_from_enemy  out  3  flight direction; 0 when no shell.
- tank_enemy_hit_us  out  1  one-cycle pulse, shell hit our tank.
- reloading  out  1  high during RELOAD.

## Operation
- Direction codes: 0 none, 1 up (y−), 2 down (y+), 3 right (x+), 4 left (x−).
- States: IDLE, FLIGHT, RELOAD.
- IDLE: fire=1 and dir_enemy in 1..4 → latch xpos/ypos_enemy into shell position, latch dir into direction_from_enemy, go FLIGHT. dir_enemy of 0 or 5..7 → request ignored.
- FLIGHT, on frame_tick: compute next position = position ± SPEED along latched axis, in 11-bit unsigned.
  - Termination checks, priority order: (1) hit: |next_x − xpos_us| ≤ HIT_HALF and |next_y − ypos_us| ≤ HIT_HALF, 12-bit compare, pulse tank_enemy_hit_us; (2) obstacle_hit=1; (3) out of bounds: borrow on subtract, or next_x > X_MAX, or next_y > Y_MAX.
  - Any termination: direction_from_enemy ← 0, position held, load reload counter with RELOAD_FRAMES−1, go RELOAD.
  - Otherwise position ← next.
- FLIGHT, no frame_tick: obstacle_hit=1 also terminates (same action, no hit pulse); other inputs ignored.
- RELOAD: counter decrements on each frame_tick; on frame_tick with counter 0 → IDLE. RELOAD_FRAMES=0 treated as 1.
- fire in FLIGHT or RELOAD is ignored (no queuing).

## Timing
- All outputs registered. Reset: state IDLE, xpos/ypos_bullet_red 0, direction_from_enemy 0, tank_enemy_hit_us 0, reloading 0, counter 0.
- fire sampled at edge N → direction and position valid after edge N.
- Position update visible the cycle after frame_tick; at most one step per frame.
- tank_enemy_hit_us high exactly one cycle, same cycle direction goes 0.
- reloading rises with termination, falls on the cycle state returns to IDLE.
- rst mid-flight: shell vanishes next cycle, no hit pulse, no reload.
- Simultaneous hit and out-of-bounds: hit wins, pulse emitted.

## Structure
- Shared package (game_pkg): direction codes DIR_NONE..DIR_LEFT, screen limits X_MAX/Y_MAX, state encoding.
- One combinational sub-module, bullet_step: current position + direction + SPEED → next position and out_of_bounds flag.

## Test plan
- Fire at (400,300), dir 1, SPEED 4 → direction 1 one cycle later; after 3 frame_ticks position (400,288).
- Fire at (400,10), dir 1 → 3rd frame_tick borrow → direction 0, no hit pulse, reloading 1 for 30 frames, then IDLE.
- Us at (460,300), fire at (400,300) dir 3 → frame_tick 11 (x=444) pulses tank_enemy_hit_us one cycle, direction 0.
- obstacle_hit asserted mid-frame during FLIGHT → direction 0 next cycle; fire during RELOAD ignored.
- fire with dir_enemy 0 or 6 → stays IDLE, outputs unchanged.
- rst during FLIGHT → all outputs 0 next cycle, reloading 0, fire accepted immediately after.
